alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Accepts load / ALU commands one at a time, drives an external 8-bit ALU
// from an internal accumulator and returns one response per command.
// State flow: IDLE -> (EXEC ->) RESP -> IDLE. Load commands skip EXEC.
module alu_cmd_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  // command channel
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_load_i,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_operand_i,
  // external ALU
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [1:0] alu_sel_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_carry_i,
  // response channel
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_carry_o,
  output logic       rsp_zero_o,
  output logic [7:0] op_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e     state_q;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [1:0] sel_q;
  logic [7:0] opnd_q;
  logic [7:0] op_count_q;
  logic       cmd_ready_q;
  logic       rsp_valid_q;

  logic cmd_fire;
  logic rsp_fire;

  // cmd_ready_q is high exactly in IDLE, so it doubles as the state qualifier.
  assign cmd_fire = cmd_valid_i & cmd_ready_q;
  assign rsp_fire = rsp_ready_i & rsp_valid_q;

  // Next accumulator / flags: only a load handshake or the EXEC cycle may change them.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    acc_d   = acc_q;
    carry_d = carry_q;
    if (state_q == IDLE && cmd_fire && cmd_load_i) begin
      acc_d   = cmd_operand_i;
      carry_d = 1'b0;
    end else if (state_q == EXEC) begin
      acc_d   = alu_result_i;
      carry_d = alu_carry_i;
    end
    zero_d = (acc_d == 8'h00);
  end

  // Control FSM plus datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= 8'h00;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      sel_q       <= 2'b00;
      opnd_q      <= 8'h00;
      op_count_q  <= 8'h00;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            if (cmd_load_i) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= EXEC;
              sel_q   <= cmd_op_i;
              opnd_q  <= cmd_operand_i;
            end
          end
        end
        EXEC: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_fire) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_count_q  <= op_count_q + 8'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ALU operands are always the held registers, so they never float between commands.
  assign alu_a_o     = acc_q;
  assign alu_b_o     = opnd_q;
  assign alu_sel_o   = sel_q;

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = acc_q;
  assign rsp_carry_o = carry_q;
  assign rsp_zero_o  = zero_q;
  assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural 8-bit ALU
// attached to the alu_* ports.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [1:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  alu_cmd_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_load_i   (cmd_load),
    .cmd_op_i     (cmd_op),
    .cmd_operand_i(cmd_operand),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_result_i (alu_result),
    .alu_carry_i  (alu_carry),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_carry_o  (rsp_carry),
    .rsp_zero_o   (rsp_zero),
    .op_count_o   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry for ADD, borrow for SUB, 0 for AND/OR.
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_sel)
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      default: ;
    endcase
  end

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; it must be accepted at the next edge.
  task automatic send_cmd(input logic load, input logic [1:0] op, input logic [7:0] opnd,
                          input string name);
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_op      = op;
    cmd_operand = opnd;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge: rsp_valid must stay low for lat
  // cycles, then show the expected response, then retire with rsp_ready.
  task automatic expect_rsp(input int lat, input logic [7:0] data, input logic carry,
                            input logic zero, input string name);
    for (int i = 0; i < lat; i++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early rsp_valid: got %b want 0", name, rsp_valid);
      end
      step();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_carry !== carry || rsp_zero !== zero) begin
      errors++;
      $display("FAIL %s rsp: got v=%b d=%h c=%b z=%b want v=1 d=%h c=%b z=%b",
               name, rsp_valid, rsp_data, rsp_carry, rsp_zero, data, carry, zero);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s retire: got v=%b rdy=%b want v=0 rdy=1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
        rsp_carry !== 1'b0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake/rsp: got rdy=%b v=%b d=%h c=%b z=%b want rdy=1 v=0 d=00 c=0 z=1",
               name, cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero);
    end
    checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 2'b00 || op_count !== 8'h00) begin
      errors++;
      $display("FAIL %s alu/count: got a=%h b=%h sel=%b cnt=%h want a=00 b=00 sel=00 cnt=00",
               name, alu_a, alu_b, alu_sel, op_count);
    end
  endtask

  task automatic check_count(input logic [7:0] exp, input string name);
    checks++;
    if (op_count !== exp) begin
      errors++;
      $display("FAIL %s op_count: got %h want %h", name, op_count, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");
    // Idle without a handshake keeps everything at reset values.
    step();
    check_reset_outputs("idle_hold");
  endtask

  task automatic test_add_chain();
    send_cmd(1'b1, OP_AND, 8'h0F, "load_0f");
    expect_rsp(0, 8'h0F, 1'b0, 1'b0, "load_0f");
    send_cmd(1'b0, OP_ADD, 8'hF5, "add_f5");
    expect_rsp(1, 8'h04, 1'b1, 1'b0, "add_f5");
    check_count(8'd2, "add_chain");
  endtask

  task automatic test_sub();
    send_cmd(1'b1, OP_AND, 8'h04, "load_04");
    expect_rsp(0, 8'h04, 1'b0, 1'b0, "load_04");
    send_cmd(1'b0, OP_SUB, 8'h05, "sub_05");
    expect_rsp(1, 8'hFF, 1'b1, 1'b0, "sub_05");
    send_cmd(1'b0, OP_SUB, 8'hFF, "sub_ff");
    expect_rsp(1, 8'h00, 1'b0, 1'b1, "sub_ff");
    check_count(8'd5, "sub");
  endtask

  task automatic test_logic();
    send_cmd(1'b1, OP_AND, 8'hF0, "load_f0");
    expect_rsp(0, 8'hF0, 1'b0, 1'b0, "load_f0");
    send_cmd(1'b0, OP_AND, 8'h3C, "and_3c");
    expect_rsp(1, 8'h30, 1'b0, 1'b0, "and_3c");
    send_cmd(1'b0, OP_OR, 8'h0F, "or_0f");
    // Now in EXEC: ALU ports must show the chained accumulator and new operand.
    checks++;
    if (alu_a !== 8'h30 || alu_b !== 8'h0F || alu_sel !== OP_OR) begin
      errors++;
      $display("FAIL exec_ports: got a=%h b=%h sel=%b want a=30 b=0f sel=01",
               alu_a, alu_b, alu_sel);
    end
    expect_rsp(1, 8'h3F, 1'b0, 1'b0, "or_0f");
    check_count(8'd8, "logic");
  endtask

  task automatic test_backpressure();
    send_cmd(1'b1, OP_AND, 8'h55, "load_55");
    // Hold the response while another command is offered.
    cmd_valid   = 1'b1;
    cmd_load    = 1'b1;
    cmd_operand = 8'hAA;
    rsp_ready   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_carry !== 1'b0 ||
          rsp_zero !== 1'b0 || cmd_ready !== 1'b0 || op_count !== 8'd8) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b d=%h c=%b z=%b rdy=%b cnt=%h want v=1 d=55 c=0 z=0 rdy=0 cnt=08",
                 i, rsp_valid, rsp_data, rsp_carry, rsp_zero, cmd_ready, op_count);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd9 || rsp_data !== 8'h55) begin
      errors++;
      $display("FAIL release: got v=%b rdy=%b cnt=%h d=%h want v=0 rdy=1 cnt=09 d=55",
               rsp_valid, cmd_ready, op_count, rsp_data);
    end
    // The command held through the stall is taken now.
    step();
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hAA) begin
      errors++;
      $display("FAIL held_cmd: got v=%b d=%h want v=1 d=aa", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_count(8'd10, "backpressure");
  endtask

  task automatic test_reset_mid_exec();
    send_cmd(1'b1, OP_AND, 8'h10, "load_10");
    expect_rsp(0, 8'h10, 1'b0, 1'b0, "load_10");
    send_cmd(1'b0, OP_ADD, 8'h20, "add_20");
    // In EXEC now; reset with rsp_ready high as well.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    step();
    rst       = 1'b0;
    check_reset_outputs("rst_exec");
    step();
    check_reset_outputs("rst_exec_after");
    rsp_ready = 1'b0;
    // Reset while a response is pending and being accepted.
    send_cmd(1'b1, OP_AND, 8'h77, "load_77");
    rst       = 1'b1;
    rsp_ready = 1'b1;
    step();
    rst       = 1'b0;
    rsp_ready = 1'b0;
    check_reset_outputs("rst_resp");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v           = 8'(i);
      cmd_valid   = 1'b1;
      cmd_load    = 1'b1;
      cmd_operand = v;
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d] cmd_ready: got %b want 1", i, cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== v || rsp_carry !== 1'b0 || rsp_zero !== (v == 8'h00)) begin
        errors++;
        $display("FAIL b2b[%0d] rsp: got v=%b d=%h c=%b z=%b want v=1 d=%h c=0 z=%b",
                 i, rsp_valid, rsp_data, rsp_carry, rsp_zero, v, (v == 8'h00));
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 8'(i + 1)) begin
        errors++;
        $display("FAIL b2b[%0d] retire: got v=%b cnt=%h want v=0 cnt=%h",
                 i, rsp_valid, op_count, 8'(i + 1));
      end
    end
    rsp_ready = 1'b0;
    check_count(8'h00, "wrap");
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_op      = 2'b00;
    cmd_operand = 8'h00;
    rsp_ready   = 1'b0;
    #2;
    test_reset();
    test_add_chain();
    test_sub();
    test_logic();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
